regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised multi-entry register file for the MIPS25 datapath; the next generation of the fixed 16-bit register.
- Holds NREGS words of WIDTH bits, with one write port and two registered read ports.
- Adds write-to-read bypass, a hardwired zero register and a synchronous bulk clear.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- NREGS, 8, number of entries (power of two, ≥2).
- AW, $clog2(NREGS), address width (derived; do not override).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes; when 0 entry 0 is an ordinary register.

Ports:
- clkpos  input  1  single system clock, rising edge active.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous clear of all entries.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- re_b  input  1  read enable, port B.
- raddr_b  input  AW  read address, port B.
- rdata_b  output  WIDTH  registered read data, port B.
- wr_cnt  output  8  saturating count of accepted writes since reset/clr.

Behaviour:
- Reset (rst=1, async): all entries, rdata_a, rdata_b and wr_cnt go to 0 immediately and are held while rst=1. The first capture happens on the first clkpos rising edge after rst falls.
- Write: on a clkpos edge with we=1 and clr=0, entry[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0: the write is dropped and wr_cnt does not increment.
  - Otherwise the write is accepted and wr_cnt increments, saturating at 255.
- Read: on a clkpos edge with re_x=1, rdata_x <= value(raddr_x). Latency is 1 cycle. With re_x=0, rdata_x holds its previous value.
- value(addr):
  - 0 if ZERO_REG=1 and addr=0;
  - else wdata if we=1, clr=0 and waddr=addr (bypass: the read returns the data being written that cycle);
  - else entry[addr].
- Both ports may read the same address in the same cycle; each returns an identical value.
- Clear: on a clkpos edge with clr=1, all entries <= 0 and wr_cnt <= 0, and any we in that cycle is ignored. Reads enabled in the same cycle return 0, because clear dominates bypass.
- rst mid-write: rst wins; the write is lost.
- Writes outside the array are impossible because NREGS is a power of two; no address wrap-around handling is needed.
- No combinational path from inputs to outputs; all outputs are flop-driven.

Decomposition:
- Package regfile_pkg holds:
  - default constants RF_WIDTH=16, RF_NREGS=8;
  - localparam CNT_MAX=255;
  - typedef rf_addr_t (logic [AW-1:0] for the default configuration).
- One sub-module, reg_word: a WIDTH-parameterised register with async active-high reset, synchronous clear and load enable.
- regfile_param instantiates NREGS copies of reg_word via a generate loop (entry 0 omitted when ZERO_REG=1), plus the read muxes, bypass logic and counter.

Test Plan:
- Reset: assert rst mid-cycle after loading entry 3=16'hBEEF. Required: rdata_a/rdata_b=0 immediately, wr_cnt=0; a later read of entry 3 returns 0.
- Write then read: we=1, waddr=5, wdata=16'h1234. Next cycle re_a=1, raddr_a=5. Required: rdata_a=16'h1234 one cycle later; wr_cnt=1.
- Bypass and dual read: we=1, waddr=2, wdata=16'hA5A5 with re_a=re_b=1, raddr_a=raddr_b=2 in the same cycle. Required: both rdata=16'hA5A5 next cycle.
- Zero register (ZERO_REG=1): write waddr=0, wdata=16'hFFFF, then read addr 0. Required: rdata=0 and wr_cnt unchanged. Rerun with ZERO_REG=0: required rdata=16'hFFFF.
- Clear vs write: fill all 8 entries, then assert clr=1 together with we=1, waddr=4, wdata=16'h7777. Required: every entry reads 0 afterwards and wr_cnt=0.
- Saturation and hold: perform 300 accepted writes. Required: wr_cnt=255. With re_a=0 while entries change, rdata_a holds its old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised MIPS25 register file.
package regfile_pkg;
    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_AW    = $clog2(RF_NREGS);
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = 255;

    typedef logic [RF_AW-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_param_if.sv
// Register-file port bundle: write port, two read ports and the write counter.
interface regfile_param_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
);
    logic             clr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re_a;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic             re_b;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic [CNT_W-1:0] wr_cnt;

    // Writeback/decode side.
    modport master (
        output clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rdata_b, wr_cnt
    );

    // Register-file side.
    modport slave (
        input  clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rdata_b, wr_cnt
    );
endinterface

// File: rtl/regfile_param_reg_word.sv
// One storage word: async reset, synchronous clear, load enable.
module reg_word
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Clear beats load so a same-cycle write never survives a bulk clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (clr)  q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/regfile_param.sv
// NREGS x WIDTH register file: one write port, two registered read ports,
// write-to-read bypass, optional hardwired zero entry, bulk clear, write counter.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clkpos,
    input  logic            rst,
    regfile_param_if.slave  bus
);
    logic [NREGS-1:0][WIDTH-1:0] entries;
    logic [WIDTH-1:0]            val_a, val_b;
    logic [WIDTH-1:0]            rdata_a, rdata_b;
    logic [CNT_W-1:0]            cnt;
    logic                        wr_ok;

    // Dropped writes (clear, or entry 0 when hardwired) never reach storage or the counter.
    assign wr_ok = bus.we && !bus.clr && !((ZERO_REG != 0) && (bus.waddr == '0));

    for (genvar i = 0; i < NREGS; i++) begin : g_word
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign entries[i] = '0;
        end else begin : g_reg
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk  (clkpos),
                .rst  (rst),
                .clr  (bus.clr),
                .load (wr_ok && (bus.waddr == AW'(i))),
                .d    (bus.wdata),
                .q    (entries[i])
            );
        end
    end

    // Read value: stored word, overridden by same-cycle write, overridden by clear.
    always_comb begin
        val_a = entries[bus.raddr_a];
        val_b = entries[bus.raddr_b];
        if (wr_ok && (bus.waddr == bus.raddr_a)) val_a = bus.wdata;
        if (wr_ok && (bus.waddr == bus.raddr_b)) val_b = bus.wdata;
        if (bus.clr) begin
            val_a = '0;
            val_b = '0;
        end
    end

    // Registered read ports; a disabled port holds its last value.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (bus.re_a) rdata_a <= val_a;
            if (bus.re_b) rdata_b <= val_b;
        end
    end

    // Saturating count of accepted writes since reset or clear.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst)                                  cnt <= '0;
        else if (bus.clr)                         cnt <= '0;
        else if (wr_ok && (cnt != CNT_W'(CNT_MAX))) cnt <= cnt + 1'b1;
    end

    assign bus.rdata_a = rdata_a;
    assign bus.rdata_b = rdata_b;
    assign bus.wr_cnt  = cnt;
endmodule

// File: tb/tb_regfile_param.sv
// Bench: a ZERO_REG=1 and a ZERO_REG=0 instance driven with identical stimulus,
// each checked against an array model of the register file.
module tb_regfile_param;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    regfile_param_if #(.WIDTH(16), .AW(3)) rf_z ();
    regfile_param_if #(.WIDTH(16), .AW(3)) rf_n ();

    assign rf_n.clr     = rf_z.clr;
    assign rf_n.we      = rf_z.we;
    assign rf_n.waddr   = rf_z.waddr;
    assign rf_n.wdata   = rf_z.wdata;
    assign rf_n.re_a    = rf_z.re_a;
    assign rf_n.raddr_a = rf_z.raddr_a;
    assign rf_n.re_b    = rf_z.re_b;
    assign rf_n.raddr_b = rf_z.raddr_b;

    regfile_param #(.WIDTH(16), .NREGS(8), .ZERO_REG(1)) dut_z (
        .clkpos (clk), .rst (rst), .bus (rf_z)
    );
    regfile_param #(.WIDTH(16), .NREGS(8), .ZERO_REG(0)) dut_n (
        .clkpos (clk), .rst (rst), .bus (rf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register contents after each edge; a read returns what the
    // addressed register holds after that edge (covers bypass and clear).
    logic [15:0] mz [8];
    logic [15:0] mn [8];
    logic [7:0]  cz, cn;
    logic [15:0] az, bz, an, bn;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mz[i] = '0;
            mn[i] = '0;
        end
        cz = '0; cn = '0; az = '0; bz = '0; an = '0; bn = '0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (rf_z.clr) begin
            for (int i = 0; i < 8; i++) begin
                mz[i] = '0;
                mn[i] = '0;
            end
            cz = '0;
            cn = '0;
        end else if (rf_z.we) begin
            if (rf_z.waddr != 0) begin
                mz[rf_z.waddr] = rf_z.wdata;
                cz = (cz == 8'd255) ? cz : cz + 8'd1;
            end
            mn[rf_z.waddr] = rf_z.wdata;
            cn = (cn == 8'd255) ? cn : cn + 8'd1;
        end
        if (rf_z.re_a) begin
            az = mz[rf_z.raddr_a];
            an = mn[rf_z.raddr_a];
        end
        if (rf_z.re_b) begin
            bz = mz[rf_z.raddr_b];
            bn = mn[rf_z.raddr_b];
        end
    endtask

    task automatic idle();
        rf_z.clr = 0; rf_z.we = 0; rf_z.waddr = '0; rf_z.wdata = '0;
        rf_z.re_a = 0; rf_z.raddr_a = '0; rf_z.re_b = 0; rf_z.raddr_b = '0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({rf_z.rdata_a, rf_z.rdata_b, rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt} !== 80'd0) begin
            errors++;
            $display("FAIL reset_state z=%h/%h/%0d n=%h/%h/%0d required all 0", rf_z.rdata_a, rf_z.rdata_b,
                     rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt);
        end
        idle();
        rf_z.we = 1; rf_z.waddr = 3; rf_z.wdata = 16'hBEEF;
        cycle();
        idle();
        rf_z.re_a = 1; rf_z.raddr_a = 3; rf_z.re_b = 1; rf_z.raddr_b = 3;
        cycle();
        checks++;
        if (rf_z.rdata_a !== 16'hBEEF || rf_z.wr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_preload got %h cnt %0d required BEEF cnt 1", rf_z.rdata_a, rf_z.wr_cnt);
        end
        idle();
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if ({rf_z.rdata_a, rf_z.rdata_b, rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt} !== 80'd0) begin
            errors++;
            $display("FAIL reset_async z=%h/%h/%0d n=%h/%h/%0d required all 0", rf_z.rdata_a, rf_z.rdata_b,
                     rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt);
        end
        rf_z.we = 1; rf_z.waddr = 6; rf_z.wdata = 16'h5555;
        cycle();
        idle();
        rst = 0;
        rf_z.re_a = 1; rf_z.raddr_a = 3; rf_z.re_b = 1; rf_z.raddr_b = 6;
        cycle();
        checks++;
        if (rf_n.rdata_a !== 16'h0 || rf_n.rdata_b !== 16'h0 || rf_n.wr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cleared got %h/%h cnt %0d required 0/0 cnt 0", rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt);
        end
        idle();
    endtask

    task automatic test_write_read();
        rf_z.we = 1; rf_z.waddr = 5; rf_z.wdata = 16'h1234;
        cycle();
        idle();
        rf_z.re_a = 1; rf_z.raddr_a = 5;
        cycle();
        checks++;
        if (rf_z.rdata_a !== 16'h1234 || rf_z.wr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL write_read got %h cnt %0d required 1234 cnt 1", rf_z.rdata_a, rf_z.wr_cnt);
        end
        idle();
    endtask

    task automatic test_bypass();
        rf_z.we = 1; rf_z.waddr = 2; rf_z.wdata = 16'hA5A5;
        rf_z.re_a = 1; rf_z.raddr_a = 2; rf_z.re_b = 1; rf_z.raddr_b = 2;
        cycle();
        checks++;
        if (rf_z.rdata_a !== 16'hA5A5 || rf_z.rdata_b !== 16'hA5A5 ||
            rf_n.rdata_a !== 16'hA5A5 || rf_n.rdata_b !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_dual got z=%h/%h n=%h/%h required A5A5", rf_z.rdata_a, rf_z.rdata_b,
                     rf_n.rdata_a, rf_n.rdata_b);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        logic [7:0] cz0, cn0;
        cz0 = rf_z.wr_cnt;
        cn0 = rf_n.wr_cnt;
        rf_z.we = 1; rf_z.waddr = 0; rf_z.wdata = 16'hFFFF;
        cycle();
        idle();
        rf_z.re_a = 1; rf_z.raddr_a = 0; rf_z.re_b = 1; rf_z.raddr_b = 0;
        cycle();
        checks++;
        if (rf_z.rdata_a !== 16'h0 || rf_z.rdata_b !== 16'h0 || rf_z.wr_cnt !== cz0) begin
            errors++;
            $display("FAIL zero_reg_on got %h/%h cnt %0d required 0/0 cnt %0d", rf_z.rdata_a, rf_z.rdata_b,
                     rf_z.wr_cnt, cz0);
        end
        checks++;
        if (rf_n.rdata_a !== 16'hFFFF || rf_n.wr_cnt !== cn0 + 8'd1) begin
            errors++;
            $display("FAIL zero_reg_off got %h cnt %0d required FFFF cnt %0d", rf_n.rdata_a, rf_n.wr_cnt, cn0 + 8'd1);
        end
        idle();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            rf_z.we = 1; rf_z.waddr = 3'(i); rf_z.wdata = 16'(16'h1000 + i * 16'h0111);
            cycle();
        end
        rf_z.clr = 1; rf_z.we = 1; rf_z.waddr = 4; rf_z.wdata = 16'h7777;
        rf_z.re_a = 1; rf_z.raddr_a = 4; rf_z.re_b = 1; rf_z.raddr_b = 7;
        cycle();
        checks++;
        if ({rf_z.rdata_a, rf_z.rdata_b, rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt} !== 80'd0) begin
            errors++;
            $display("FAIL clear_same_cycle z=%h/%h/%0d n=%h/%h/%0d required all 0", rf_z.rdata_a, rf_z.rdata_b,
                     rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rf_z.re_a = 1; rf_z.raddr_a = 3'(2 * i); rf_z.re_b = 1; rf_z.raddr_b = 3'(2 * i + 1);
            cycle();
            checks++;
            if ({rf_z.rdata_a, rf_z.rdata_b, rf_n.rdata_a, rf_n.rdata_b} !== 64'd0 || rf_n.wr_cnt !== 8'd0) begin
                errors++;
                $display("FAIL clear_entries pair %0d z=%h/%h n=%h/%h cnt %0d required 0", i, rf_z.rdata_a,
                         rf_z.rdata_b, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rf_z.clr     = ($urandom_range(0, 29) == 0);
            rf_z.we      = $urandom_range(0, 3) != 0;
            rf_z.waddr   = 3'($urandom_range(0, 7));
            rf_z.wdata   = 16'($urandom);
            rf_z.re_a    = $urandom_range(0, 3) != 0;
            rf_z.raddr_a = ($urandom_range(0, 2) == 0) ? rf_z.waddr : 3'($urandom_range(0, 7));
            rf_z.re_b    = $urandom_range(0, 3) != 0;
            rf_z.raddr_b = ($urandom_range(0, 3) == 0) ? rf_z.raddr_a : 3'($urandom_range(0, 7));
            cycle();
            checks++;
            if ({rf_z.rdata_a, rf_z.rdata_b, rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt} !==
                {az, bz, cz, an, bn, cn}) begin
                errors++;
                $display("FAIL random_%0d z=%h/%h/%0d n=%h/%h/%0d required z=%h/%h/%0d n=%h/%h/%0d", n,
                         rf_z.rdata_a, rf_z.rdata_b, rf_z.wr_cnt, rf_n.rdata_a, rf_n.rdata_b, rf_n.wr_cnt,
                         az, bz, cz, an, bn, cn);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [15:0] held;
        rf_z.clr = 1;
        cycle();
        idle();
        rf_z.we = 1; rf_z.waddr = 1; rf_z.wdata = 16'hC0DE;
        rf_z.re_a = 1; rf_z.raddr_a = 1;
        cycle();
        held = 16'hC0DE;
        idle();
        for (int n = 0; n < 299; n++) begin
            rf_z.we = 1; rf_z.waddr = 3'($urandom_range(1, 7)); rf_z.wdata = 16'($urandom);
            rf_z.re_b = 1; rf_z.raddr_b = rf_z.waddr;
            cycle();
        end
        idle();
        checks++;
        if (rf_z.wr_cnt !== 8'd255 || rf_n.wr_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturation got z=%0d n=%0d required 255", rf_z.wr_cnt, rf_n.wr_cnt);
        end
        checks++;
        if (rf_z.rdata_a !== held || rf_n.rdata_a !== held) begin
            errors++;
            $display("FAIL read_hold got z=%h n=%h required %h", rf_z.rdata_a, rf_n.rdata_a, held);
        end
        checks++;
        if (rf_z.rdata_b !== bz || rf_n.rdata_b !== bn) begin
            errors++;
            $display("FAIL sat_last_read got z=%h n=%h required %h/%h", rf_z.rdata_b, rf_n.rdata_b, bz, bn);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
